// File: rtl/stream_width_downsizer.sv
// Serialises each IN_WIDTH-bit word into RATIO OUT_WIDTH-bit beats on a valid/ready channel.
// Define STREAM_DWS_MSB_FIRST_EN to emit the most significant slice first instead of LSB-first.
module stream_width_downsizer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = IN_WIDTH / OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    input  logic                 out_ready
);

    localparam int IDX_W = $clog2(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    generate
        if (RATIO < 2 || (IN_WIDTH % OUT_WIDTH) != 0 || RATIO != IN_WIDTH / OUT_WIDTH) begin : g_bad_cfg
            $error("stream_width_downsizer: IN_WIDTH must be an integer multiple (>=2) of OUT_WIDTH");
        end
    endgenerate

    typedef enum logic {
        EMPTY,
        SERIALISING
    } state_t;

    state_t              state_p0, state_nxt;
    logic [IDX_W-1:0]    idx_p0, idx_nxt;
    logic [IN_WIDTH-1:0] hold_p0, hold_nxt;
    logic                full;
    logic                at_last;
    logic                push;
    logic                pop;
    logic                last_pop;
    int                  sel_base;

    function automatic logic [IDX_W-1:0] beat_sel(input logic [IDX_W-1:0] idx);
`ifdef STREAM_DWS_MSB_FIRST_EN
        return LAST_IDX - idx;
`else
        return idx;
`endif
    endfunction

    assign full      = (state_p0 == SERIALISING);
    assign at_last   = (idx_p0 == LAST_IDX);
    assign out_valid = full && !rst;
    assign out_last  = out_valid && at_last;
    assign pop       = out_valid && out_ready;
    assign last_pop  = pop && at_last;
    // Accepting on the final pop keeps the output busy every cycle across word boundaries.
    assign in_ready  = !rst && (!full || last_pop);
    assign push      = in_valid && in_ready;

    always_comb begin
        sel_base = int'(beat_sel(idx_p0)) * OUT_WIDTH;
        out_data = hold_p0[sel_base +: OUT_WIDTH];
    end

    always_comb begin
        state_nxt = state_p0;
        idx_nxt   = idx_p0;
        hold_nxt  = hold_p0;
        case (state_p0)
            EMPTY: begin
                if (push) begin
                    hold_nxt  = in_data;
                    idx_nxt   = '0;
                    state_nxt = SERIALISING;
                end
            end
            SERIALISING: begin
                if (pop) begin
                    if (!at_last) begin
                        idx_nxt = idx_p0 + 1'b1;
                    end else begin
                        idx_nxt = '0;
                        if (push) begin
                            hold_nxt = in_data;
                        end else begin
                            state_nxt = EMPTY;
                        end
                    end
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Register stage: word holding register, beat index and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= EMPTY;
            idx_p0   <= '0;
            hold_p0  <= '0;
        end else begin
            state_p0 <= state_nxt;
            idx_p0   <= idx_nxt;
            hold_p0  <= hold_nxt;
        end
    end

endmodule

// File: doc/stream_width_downsizer.md
Name: stream_width_downsizer

Overview:
- Sits directly downstream of the single-entry valid/ready pipeline stage and consumes its output stream.
- Takes each IN_WIDTH-bit word and serialises it into RATIO consecutive OUT_WIDTH-bit beats on a narrower valid/ready channel.
- Flags the final beat of each word with out_last.
- Holds one word internally and accepts the next word in the same cycle the last beat leaves, so it sustains one output beat per cycle.

Parameters:
- IN_WIDTH, 32, input word width in bits.
- OUT_WIDTH, 8, output beat width in bits. IN_WIDTH must be an integer multiple of OUT_WIDTH.
- RATIO, IN_WIDTH/OUT_WIDTH, beats per word; derived, do not override. Elaboration error if RATIO < 2 or IN_WIDTH % OUT_WIDTH != 0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream word valid.
- in_data  input  IN_WIDTH  upstream word.
- in_ready  output  1  block can accept a word this cycle.
- out_valid  output  1  beat valid.
- out_data  output  OUT_WIDTH  current beat.
- out_last  output  1  current beat is the final slice of its word.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- Single clock. All state updates on posedge clk. Reset is sampled only on clock edges, active-high.
- Reset values: full=0, beat counter idx=0, holding register=0. Outputs: out_valid=0, out_data=0, out_last=0. in_ready=0 while rst is high.
- Handshake events:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - last_pop = pop && (idx == RATIO-1).
- Combinational outputs (rst low):
  - in_ready = ~full || last_pop. This is a combinational path from out_ready to in_ready.
  - out_valid = full.
  - out_last = full && (idx == RATIO-1).
  - out_data = holding register slice idx, bits [idx*OUT_WIDTH +: OUT_WIDTH]. Slice 0 is the LSBs, so slices go out LSB-first.
- States: EMPTY (full=0) and SERIALISING (full=1, idx 0..RATIO-1).
- Transitions:
  - EMPTY & push: capture in_data, idx<=0, full<=1.
  - SERIALISING & pop & not last: idx<=idx+1. Data is held.
  - SERIALISING & last_pop & push: capture in_data, idx<=0, full stays 1. Zero bubble.
  - SERIALISING & last_pop & ~push: full<=0, idx<=0.
  - SERIALISING & ~pop: hold everything. out_data and out_last stay stable, per valid/ready rules.
- Latency: first beat is valid the cycle after the word is accepted. Word N+1's first beat follows word N's last beat with no idle cycle if in_valid is ready in time.
- idx never exceeds RATIO-1. It wraps to 0 only through the transitions above.
- out_valid never drops without a pop. in_data is ignored when ~in_ready.
- Reset mid-word: the partially sent word is discarded. No further beats are issued from it. The next accepted word starts at slice 0.
- Throughput: one word per RATIO cycles under full out_ready.

Optional Feature:
- Macro: STREAM_DWS_MSB_FIRST_EN.
- When defined: beat order is reversed. out_data = slice (RATIO-1-idx), so the most significant slice goes first. out_last still asserts at idx==RATIO-1.
- When undefined: LSB-first order as above.
- Handshake, latency and reset behaviour are identical in both builds.

Test Plan:
- Single word, out_ready=1: push 0xDDCCBBAA. Response: out_data 0xAA,0xBB,0xCC,0xDD on 4 consecutive cycles starting the cycle after push. out_last=1 only on 0xDD. in_ready=0 for the first three beats and 1 on the 0xDD cycle.
- Back-to-back: in_valid held high with 0x44332211 then 0x88776655, out_ready=1. Response: 8 consecutive beats 0x11..0x88 with no gap. Second push occurs in the same cycle as beat 0x44.
- Backpressure: during 0xDDCCBBAA, drop out_ready for 3 cycles while 0xBB is presented. Response: out_valid=1, out_data=0xBB, out_last=0 stable all 3 cycles. Sequence then resumes with 0xCC, 0xDD.
- Reset mid-word: assert rst for 1 cycle after beat 0xAA pops. Response: next cycle out_valid=0, in_ready=1. Push 0x12345678, which yields 0x78,0x56,0x34,0x12 with no leftover 0xBB.
- Idle/no push: in_valid=0 for 10 cycles after reset. Response: out_valid=0 and in_ready=1 throughout.
- STREAM_DWS_MSB_FIRST_EN build: push 0xDDCCBBAA. Response: 0xDD,0xCC,0xBB,0xAA, with out_last on 0xAA.
